// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - SIPO frame sequencer: serial accept, word hold under backpressure
// Optional parity stage enabled by defining SIPO_FRAME_PARITY_EN.
module sipo_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       ser_in,
    input  logic                       ser_valid,
    output logic                       ser_ready,
    output logic [WIDTH-1:0]           par_out,
    output logic                       par_valid,
    input  logic                       par_ready,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;
`ifdef SIPO_FRAME_PARITY_EN
    localparam logic [1:0] PARITY = 2'd3;
    localparam logic [1:0] AFTER_DATA = PARITY;
`else
    localparam logic [1:0] AFTER_DATA = HOLD;
`endif

    logic [1:0]       state;
    logic [WIDTH-1:0] sr;
    logic             frame_start;

    // A new frame begins from IDLE, or straight from HOLD when the word is consumed.
    assign frame_start = start & ((state == IDLE) | ((state == HOLD) & par_ready));

    // Handshake outputs depend on state only, so no ser_valid/par_ready feed-through.
`ifdef SIPO_FRAME_PARITY_EN
    assign ser_ready = (state == SHIFT) | (state == PARITY);
`else
    assign ser_ready = (state == SHIFT);
`endif
    assign par_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign par_out   = sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SHIFT;
                        sr      <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // abort wins over a coincident bit accept
                    if (abort) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (ser_valid) begin
                        sr      <= {ser_in, sr[WIDTH-1:1]};
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= AFTER_DATA;
                        end
                    end
                end
`ifdef SIPO_FRAME_PARITY_EN
                PARITY: begin
                    if (abort) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (ser_valid) begin
                        state <= HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (par_ready) begin
                        if (start) begin
                            state   <= SHIFT;
                            sr      <= '0;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SIPO_FRAME_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (frame_start) begin
            parity_err <= 1'b0;
        end else if ((state == PARITY) && ser_valid && !abort) begin
            // even parity over data plus parity bit; 1 flags an error
            parity_err <= (^sr) ^ ser_in;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb/tb_sipo_frame_ctrl.sv - directed self-checking bench for sipo_frame_ctrl (WIDTH=4)
module tb_sipo_frame_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       ser_in;
    logic       ser_valid;
    logic       ser_ready;
    logic [3:0] par_out;
    logic       par_valid;
    logic       par_ready;
    logic       busy;
    logic [2:0] bit_cnt;
    logic       parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    sipo_frame_ctrl #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .par_out    (par_out),
        .par_valid  (par_valid),
        .par_ready  (par_ready),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_valid = 1'b1;
        ser_in    = b;
        tick();
        ser_valid = 1'b0;
    endtask

    task automatic begin_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Parity bit only exists in the parity build; default build lands in HOLD after data.
    task automatic send_parity(input logic p, input logic exp_err);
`ifdef SIPO_FRAME_PARITY_EN
        check("parity_state_ready", ser_ready, 1'b1);
        check("parity_state_pvalid", par_valid, 1'b0);
        check("parity_state_cnt", bit_cnt, 3'd4);
        send_bit(p);
        check("parity_err", parity_err, exp_err);
`else
        check("parity_err_tied", parity_err, 1'b0);
        if (p && exp_err) check("unused_args", 1'b0, 1'b0);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        ser_in = 1'b0; ser_valid = 1'b0; par_ready = 1'b0;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_ser_ready", ser_ready, 1'b0);
        check("rst_par_valid", par_valid, 1'b0);
        check("rst_bit_cnt", bit_cnt, 3'd0);
        check("rst_par_out", par_out, 4'h0);
        check("rst_parity_err", parity_err, 1'b0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);

        // Frame 1: 1,0,1,1 back to back
        begin_frame();
        check("f1_busy", busy, 1'b1);
        check("f1_ser_ready", ser_ready, 1'b1);
        check("f1_cnt0", bit_cnt, 3'd0);
        ser_valid = 1'b1;
        ser_in = 1'b1; tick();
        ser_in = 1'b0; tick();
        ser_in = 1'b1; tick();
        check("f1_cnt3", bit_cnt, 3'd3);
        check("f1_pvalid_early", par_valid, 1'b0);
        ser_in = 1'b1; tick();
        ser_valid = 1'b0;
        send_parity(1'b1, 1'b0);
        check("f1_par_valid", par_valid, 1'b1);
        check("f1_par_out", par_out, 4'hD);
        check("f1_bit_cnt", bit_cnt, 3'd4);
        check("f1_busy_hold", busy, 1'b1);
        check("f1_ser_ready_hold", ser_ready, 1'b0);
        par_ready = 1'b1;
        tick();
        par_ready = 1'b0;
        check("f1_idle_busy", busy, 1'b0);
        check("f1_idle_pvalid", par_valid, 1'b0);

        // Frame 2: gap of 3 cycles after 2 bits, then long backpressure
        begin_frame();
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("f2_gap_cnt", bit_cnt, 3'd2);
            check("f2_gap_ready", ser_ready, 1'b1);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        send_parity(1'b0, 1'b1);
        check("f2_par_out", par_out, 4'hD);
        check("f2_par_valid", par_valid, 1'b1);
        for (int i = 0; i < 6; i++) begin
            ser_valid = 1'b1;
            ser_in    = i[0];
            abort     = (i == 2);
            tick();
            check("f2_hold_valid", par_valid, 1'b1);
            check("f2_hold_out", par_out, 4'hD);
            check("f2_hold_ready", ser_ready, 1'b0);
            check("f2_hold_cnt", bit_cnt, 3'd4);
        end
        ser_valid = 1'b0; abort = 1'b0;
        par_ready = 1'b1;
        tick();
        par_ready = 1'b0;
        check("f2_release_idle", busy, 1'b0);

        // Frame 3: aborted after 2 bits (abort coincident with a valid bit)
        begin_frame();
        send_bit(1'b1);
        send_bit(1'b1);
        check("f3_cnt2", bit_cnt, 3'd2);
        abort = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
        tick();
        abort = 1'b0; ser_valid = 1'b0;
        check("f3_abort_busy", busy, 1'b0);
        check("f3_abort_cnt", bit_cnt, 3'd0);
        check("f3_abort_pvalid", par_valid, 1'b0);
        tick();
        check("f3_no_word", par_valid, 1'b0);

        // Frame 4: 0,1,1,0 -> 6
        begin_frame();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_parity(1'b0, 1'b0);
        check("f4_par_valid", par_valid, 1'b1);
        check("f4_par_out", par_out, 4'h6);

        // Back-to-back start from HOLD
        par_ready = 1'b1; start = 1'b1;
        tick();
        par_ready = 1'b0; start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_ser_ready", ser_ready, 1'b1);
        check("b2b_par_valid", par_valid, 1'b0);
        check("b2b_cnt", bit_cnt, 3'd0);
        check("b2b_sr_clr", par_out, 4'h0);

        // Async reset mid-frame after 3 bits
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("mid_cnt3", bit_cnt, 3'd3);
        check("mid_sr", par_out, 4'hE);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_cnt", bit_cnt, 3'd0);
        check("arst_par_out", par_out, 4'h0);
        check("arst_ser_ready", ser_ready, 1'b0);
        check("arst_par_valid", par_valid, 1'b0);
        check("arst_parity_err", parity_err, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
